// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, FSM states and zero-register index for operand fetch
// Contents: DATA_W/ADDR_W defaults, fetch_state_t (IDLE, READ, CAPTURE, HOLD), ZERO_REG index.
package regfile_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/regfile_operand_fetch_if.sv
// rtl/regfile_operand_fetch_if.sv - request, writeback, register file and operand signals
// Modports:
//   master - operand fetch side: takes req_*/wb_*/rf_read_data*/op_ready, drives the rest.
//   slave  - surrounding datapath: decode, writeback, register file and execute.
interface regfile_operand_fetch_if #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_rs1;
  logic [ADDR_W-1:0] req_rs2;
  logic [ADDR_W-1:0] req_rd;

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;

  logic              rf_E;
  logic              rf_register_write;
  logic [ADDR_W-1:0] rf_write_register;
  logic [DATA_W-1:0] rf_write_data;
  logic [ADDR_W-1:0] rf_read_register1;
  logic [ADDR_W-1:0] rf_read_register2;
  logic [DATA_W-1:0] rf_read_data1;
  logic [DATA_W-1:0] rf_read_data2;

  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [ADDR_W-1:0] op_rd;

  modport master (
    input  req_valid, req_rs1, req_rs2, req_rd,
    output req_ready,
    input  wb_valid, wb_rd, wb_data,
    output rf_E, rf_register_write, rf_write_register, rf_write_data,
    output rf_read_register1, rf_read_register2,
    input  rf_read_data1, rf_read_data2,
    output op_valid, op_a, op_b, op_rd,
    input  op_ready
  );

  modport slave (
    output req_valid, req_rs1, req_rs2, req_rd,
    input  req_ready,
    output wb_valid, wb_rd, wb_data,
    input  rf_E, rf_register_write, rf_write_register, rf_write_data,
    input  rf_read_register1, rf_read_register2,
    output rf_read_data1, rf_read_data2,
    input  op_valid, op_a, op_b, op_rd,
    output op_ready
  );

endinterface

// File: rtl/regfile_operand_bypass.sv
// rtl/regfile_operand_bypass.sv - per-operand writeback forward mux
// Ports: idx (operand register index), cur_value (value without forwarding),
//        wb_valid/wb_rd/wb_data (writeback stream), next_value (forwarded result).
// Optional macro ZERO_REG_EN: index 0 always yields zero and never forwards.
module regfile_operand_bypass
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] cur_value,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] next_value
);

  always_comb begin
    next_value = cur_value;
    if (wb_valid && (wb_rd == idx)) begin
      next_value = wb_data;
    end
`ifdef ZERO_REG_EN
    // Masking the result also covers the "never forward to r0" rule.
    if (idx == ADDR_W'(ZERO_REG)) begin
      next_value = '0;
    end
`endif
  end

endmodule

// File: rtl/regfile_operand_fetch.sv
// rtl/regfile_operand_fetch.sv - operand fetch between decode and execute over a registered-read register file
// Ports: clk, rst (synchronous, active-high), bus (regfile_operand_fetch_if.master):
//   req_*  decoded operand request (valid/ready), wb_* writeback stream (never stalled),
//   rf_*   register file write port and registered read port, op_* operands to execute (valid/ready).
// Optional macro ZERO_REG_EN: register 0 is hardwired to zero.
module regfile_operand_fetch
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_operand_fetch_if.master bus
);

  fetch_state_t state_q, state_d;

  logic [ADDR_W-1:0] rs1_q, rs2_q, rd_q;
  logic [DATA_W-1:0] op_a_q, op_b_q;
  logic [ADDR_W-1:0] op_rd_q;

  logic              accept;
  logic              capture;
  logic              track;
  logic              wb_write;
  logic [DATA_W-1:0] cur_a, cur_b;
  logic [DATA_W-1:0] next_a, next_b;

  // Write port is a straight pass-through of the writeback stream.
  always_comb begin
    wb_write = bus.wb_valid & ~rst;
`ifdef ZERO_REG_EN
    if (bus.wb_rd == ADDR_W'(ZERO_REG)) begin
      wb_write = 1'b0;
    end
`endif
  end

  assign bus.rf_E              = wb_write;
  assign bus.rf_register_write = wb_write;
  assign bus.rf_write_register = bus.wb_rd;
  assign bus.rf_write_data     = bus.wb_data;
  assign bus.rf_read_register1 = rs1_q;
  assign bus.rf_read_register2 = rs2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.op_valid  = 1'b0;
    accept        = 1'b0;
    capture       = 1'b0;
    track         = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = READ;
        end
      end
      // The register file samples the latched addresses at the end of this
      // cycle with any same-edge write already applied.
      READ: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        capture = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        bus.op_valid = 1'b1;
        if (bus.op_ready) begin
          state_d = IDLE;
        end else begin
          // Consumer has not taken the operands yet, so keep them current.
          track = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // In CAPTURE the base value is fresh register file data; in HOLD it is the held operand.
  assign cur_a = capture ? bus.rf_read_data1 : op_a_q;
  assign cur_b = capture ? bus.rf_read_data2 : op_b_q;

  regfile_operand_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bypass_a (
    .idx        (rs1_q),
    .cur_value  (cur_a),
    .wb_valid   (bus.wb_valid),
    .wb_rd      (bus.wb_rd),
    .wb_data    (bus.wb_data),
    .next_value (next_a)
  );

  regfile_operand_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bypass_b (
    .idx        (rs2_q),
    .cur_value  (cur_b),
    .wb_valid   (bus.wb_valid),
    .wb_rd      (bus.wb_rd),
    .wb_data    (bus.wb_data),
    .next_value (next_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      op_rd_q <= '0;
    end else begin
      if (accept) begin
        rs1_q <= bus.req_rs1;
        rs2_q <= bus.req_rs2;
        rd_q  <= bus.req_rd;
      end
      if (capture || track) begin
        op_a_q <= next_a;
        op_b_q <= next_b;
      end
      if (capture) begin
        op_rd_q <= rd_q;
      end
    end
  end

  assign bus.op_a  = op_a_q;
  assign bus.op_b  = op_b_q;
  assign bus.op_rd = op_rd_q;

endmodule

// File: doc/regfile_operand_fetch.md
Name: regfile_operand_fetch

Overview:
- Initiator side of the 64-bit register file port: takes decoded operand requests (rs1, rs2, rd), drives the register file's read/write ports, and returns both source operands over a valid/ready handshake.
- Also owns the register file write port, driving it from the writeback stream.
- Accounts for the register file's registered reads (data appears the cycle after the address edge).
- Forwards writebacks that the register file cannot yet reflect.
- Sits between decode and execute in the CPU datapath.

Parameters:
- DATA_W, 64, operand/writeback data width.
- ADDR_W, 5, register index width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  operand request valid.
- req_ready  output  1  controller can accept a request.
- req_rs1  input  ADDR_W  source register 1 index.
- req_rs2  input  ADDR_W  source register 2 index.
- req_rd  input  ADDR_W  destination index, passed through.
- wb_valid  input  1  writeback valid; always accepted, no ready.
- wb_rd  input  ADDR_W  writeback register index.
- wb_data  input  DATA_W  writeback data.
- rf_E  output  1  register file enable.
- rf_register_write  output  1  register file write strobe.
- rf_write_register  output  ADDR_W  register file write index.
- rf_write_data  output  DATA_W  register file write data.
- rf_read_register1  output  ADDR_W  register file read index 1.
- rf_read_register2  output  ADDR_W  register file read index 2.
- rf_read_data1  input  DATA_W  registered read data 1.
- rf_read_data2  input  DATA_W  registered read data 2.
- op_valid  output  1  operands valid.
- op_ready  input  1  consumer accepts operands.
- op_a  output  DATA_W  operand for rs1.
- op_b  output  DATA_W  operand for rs2.
- op_rd  output  ADDR_W  destination index for the held operands.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values: state IDLE; req_ready 1; op_valid 0; op_a, op_b, op_rd 0; latched rs1/rs2/rd 0.
- Reset mid-operation discards any in-flight request; no operands are emitted.
- Write port (combinational from wb_*):
  - rf_E = rf_register_write = wb_valid & ~rst.
  - rf_write_register = wb_rd; rf_write_data = wb_data.
  - Writes are never stalled.
- Read addresses: rf_read_register1/2 always drive the latched rs1/rs2 registers.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch rs1/rs2/rd and go to READ.
  - READ: req_ready=0. The register file samples the addresses at the end-of-cycle edge, with a same-edge write already included, so no forwarding is needed here. Go to CAPTURE.
  - CAPTURE: rf_read_data1/2 are valid. Latch op_a/op_b with forwarding (below), set op_rd. Set op_valid at the edge and go to HOLD.
  - HOLD: op_valid=1; op_a/op_b/op_rd stable except for forwarding. On op_ready, clear op_valid and go to IDLE.
- Back-to-back: a new request can first be accepted the cycle after op_ready handshakes.
- Latency: request handshake at edge E0 -> op_valid high in the cycle after edge E0+2 (3-cycle latency minimum).
- Forwarding:
  - In CAPTURE, if wb_valid and wb_rd==rs1, op_a takes wb_data instead of rf_read_data1; same rule for rs2/op_b.
  - In HOLD, a matching writeback overwrites the held op_a/op_b at that edge, so operands always track the latest architectural value.
  - rs1==rs2 matching one writeback updates both operands.
- Simultaneous events:
  - A writeback in the request-acceptance cycle is written at E0 and read correctly at E1.
  - op_ready together with a matching writeback in HOLD: the handshake completes and the forwarded value is dropped (consumer saw the pre-write value, by design).

Optional Feature:
- Macro ZERO_REG_EN.
- When defined, register 0 is hardwired to zero:
  - writebacks with wb_rd==0 do not assert rf_E/rf_register_write;
  - operands for index 0 read as 0 regardless of rf_read_data;
  - forwarding never matches index 0.
- When undefined, register 0 behaves like any other register.

Decomposition:
- Shared package regfile_pkg: DATA_W/ADDR_W constants, FSM state typedef (IDLE, READ, CAPTURE, HOLD), zero-register index constant.
- One sub-module: regfile_operand_bypass. It is a per-operand forward mux: inputs are the index, current value, wb_valid, wb_rd and wb_data; output is the next value, including the ZERO_REG_EN masking. It is instantiated twice.

Test Plan:
- Reset then request rs1=3, rs2=4, rd=5 with regs 3=0x11, 4=0x22 -> op_valid 3 cycles after handshake, op_a=0x11, op_b=0x22, op_rd=5.
- Writeback reg 3=0xAA in the CAPTURE cycle of a rs1=3 request -> op_a=0xAA (forwarded), op_b unchanged.
- Hold op_ready=0 for 4 cycles; writeback reg 4=0xBEEF during HOLD -> op_b becomes 0xBEEF next cycle, op_valid stays 1, req_ready stays 0.
- rs1=rs2=7, writeback 7=0x5 in READ -> op_a=op_b=0x5 via the register file path; rf_register_write pulses exactly 1 cycle.
- Assert rst in CAPTURE -> next cycle op_valid=0, req_ready=1, op_a=op_b=0; the following request completes normally.
- With ZERO_REG_EN: writeback 0=0xFF -> rf_register_write stays 0; request rs1=0 -> op_a=0.
